// File: rtl/lsu_misalign_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_misalign_unit_pkg
//   Shared types and helpers for the MEM-stage load/store unit.
//   - mem_op_t    : memory operation encoding seen by the LSU and data_memory
//   - lsu_state_t : LSU sequencing state (idle / byte-split in progress)
//   - mem_op_size, mem_op_is_load, mem_op_is_store, mem_op_misaligned
// ---------------------------------------------------------------------------
package lsu_misalign_unit_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef enum logic {
        LSU_IDLE  = 1'b0,
        LSU_SPLIT = 1'b1
    } lsu_state_t;

    // Access size in bytes; 0 for MEM_NOP.
    function automatic logic [2:0] mem_op_size(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: mem_op_size = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: mem_op_size = 3'd2;
            MEM_LW, MEM_SW:          mem_op_size = 3'd4;
            default:                 mem_op_size = 3'd0;
        endcase
    endfunction

    function automatic logic mem_op_is_load(input mem_op_t op);
        mem_op_is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                         (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic mem_op_is_store(input mem_op_t op);
        mem_op_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic mem_op_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
        case (mem_op_size(op))
            3'd2:    mem_op_misaligned = addr_lo[0];
            3'd4:    mem_op_misaligned = (addr_lo != 2'b00);
            default: mem_op_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_misalign_unit_load_extend.sv
// ---------------------------------------------------------------------------
// lsu_misalign_unit_load_extend
//   Combinational load_extend stage: takes the low byte / halfword / word of
//   a raw 32-bit value and sign- or zero-extends it according to the load op.
//   Ports:
//     op   : load operation selecting width and signedness
//     raw  : raw little-endian data (byte 0 in bits [7:0])
//     data : extended result (0 for non-load ops)
// ---------------------------------------------------------------------------
module lsu_misalign_unit_load_extend
    import lsu_misalign_unit_pkg::*;
(
    input  mem_op_t     op,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = 32'd0;
        case (op)
            MEM_LB:  data = {{24{raw[7]}}, raw[7:0]};
            MEM_LBU: data = {24'd0, raw[7:0]};
            MEM_LH:  data = {{16{raw[15]}}, raw[15:0]};
            MEM_LHU: data = {16'd0, raw[15:0]};
            MEM_LW:  data = raw;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_unit.sv
// ---------------------------------------------------------------------------
// lsu_misalign_unit
//   MEM-stage load/store unit sitting between the EX/MEM register and
//   data_memory. Aligned accesses pass straight through combinationally.
//   Misaligned halfword/word accesses are split into byte accesses
//   (MEM_LBU / MEM_SB) over consecutive cycles while stall holds the pipe.
//
//   Handshake: stall is the inverse of "ready". A request on req_* is
//   accepted in the first cycle stall is low; the caller must hold req_*
//   stable while stall is high. load_data is valid in the cycle stall is low
//   for a load op (and flush is low).
//
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     flush             : abandon any in-flight split, suppress this access
//     req_op/addr/wdata : request from EX/MEM
//     dmem_*            : data_memory interface (combinational read data)
//     load_data         : extended load result
//     stall             : hold upstream pipeline
//     misalign_exc      : misaligned op suppressed (ALLOW_MISALIGNED = 0)
//     split_count       : saturating count of split accesses started
// ---------------------------------------------------------------------------
module lsu_misalign_unit
    import lsu_misalign_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dmem_wr_en,
    output mem_op_t     dmem_ctrl,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign_exc,
    output logic [15:0] split_count
);

    lsu_state_t       state;
    logic [1:0]       byte_idx;
    logic [2:0][7:0]  byte_buf;
    mem_op_t          lat_op;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic             req_mis;
    logic             start_split;
    logic             split_last;
    logic [2:0]       lat_last_idx;
    logic [7:0]       cur_byte;
    logic [31:0]      assembled;
    mem_op_t          ext_op;
    logic [31:0]      ext_raw;
    logic [31:0]      ext_data;

    // One extender serves both the pass-through path and the split assembly.
    lsu_misalign_unit_load_extend u_load_extend (
        .op   (ext_op),
        .raw  (ext_raw),
        .data (ext_data)
    );

    always_comb begin
        req_mis      = (req_op != MEM_NOP) && mem_op_misaligned(req_op, req_addr[1:0]);
        start_split  = 1'b0;
        lat_last_idx = mem_op_size(lat_op) - 3'd1;
        split_last   = ({1'b0, byte_idx} == lat_last_idx);
        cur_byte     = dmem_rdata[7:0];

        // Final byte of the split joins the bytes captured in earlier cycles.
        if (mem_op_size(lat_op) == 3'd2)
            assembled = {16'd0, cur_byte, byte_buf[0]};
        else
            assembled = {cur_byte, byte_buf[2], byte_buf[1], byte_buf[0]};

        ext_op       = (state == LSU_SPLIT) ? lat_op : req_op;
        ext_raw      = (state == LSU_SPLIT) ? assembled : dmem_rdata;

        dmem_wr_en   = 1'b0;
        dmem_ctrl    = MEM_NOP;
        dmem_addr    = 32'd0;
        dmem_wdata   = 32'd0;
        load_data    = 32'd0;
        stall        = 1'b0;
        misalign_exc = 1'b0;

        case (state)
            LSU_IDLE: begin
                if (flush) begin
                    // Access suppressed; outputs stay at their idle values.
                end else if (req_mis) begin
                    if (ALLOW_MISALIGNED) begin
                        start_split = 1'b1;
                        dmem_ctrl   = mem_op_is_load(req_op) ? MEM_LBU : MEM_SB;
                        dmem_wr_en  = mem_op_is_store(req_op);
                        dmem_addr   = req_addr;
                        dmem_wdata  = {24'd0, req_wdata[7:0]};
                        stall       = 1'b1;
                    end else begin
                        misalign_exc = 1'b1;
                    end
                end else begin
                    dmem_ctrl  = req_op;
                    dmem_wr_en = mem_op_is_store(req_op);
                    dmem_addr  = req_addr;
                    dmem_wdata = req_wdata;
                    load_data  = ext_data;
                end
            end
            LSU_SPLIT: begin
                if (!flush) begin
                    dmem_ctrl  = mem_op_is_load(lat_op) ? MEM_LBU : MEM_SB;
                    dmem_wr_en = mem_op_is_store(lat_op);
                    dmem_addr  = lat_addr + {30'd0, byte_idx};
                    dmem_wdata = {24'd0, lat_wdata[{byte_idx, 3'b000} +: 8]};
                    stall      = !split_last;
                    if (split_last)
                        load_data = ext_data;
                end
            end
            default: ;
        endcase

        // Reset forces every output quiet even though the pass-through is combinational.
        if (!rst_n) begin
            start_split  = 1'b0;
            dmem_wr_en   = 1'b0;
            dmem_ctrl    = MEM_NOP;
            dmem_addr    = 32'd0;
            dmem_wdata   = 32'd0;
            load_data    = 32'd0;
            stall        = 1'b0;
            misalign_exc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LSU_IDLE;
            byte_idx    <= 2'd0;
            byte_buf    <= '0;
            lat_op      <= MEM_NOP;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            split_count <= 16'd0;
        end else if (flush) begin
            state    <= LSU_IDLE;
            byte_idx <= 2'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (start_split) begin
                        state       <= LSU_SPLIT;
                        byte_idx    <= 2'd1;
                        byte_buf[0] <= cur_byte;
                        lat_op      <= req_op;
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        if (split_count != 16'hFFFF)
                            split_count <= split_count + 16'd1;
                    end
                end
                LSU_SPLIT: begin
                    if (split_last) begin
                        state    <= LSU_IDLE;
                        byte_idx <= 2'd0;
                    end else begin
                        case (byte_idx)
                            2'd1:    byte_buf[1] <= cur_byte;
                            2'd2:    byte_buf[2] <= cur_byte;
                            default: ;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_misalign_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_misalign_unit
//   Two unit instances, each with a byte-array data_memory behind it:
//   dut (ALLOW_MISALIGNED=1) and dut_nm (ALLOW_MISALIGNED=0).
//   Load results of dut go through an expected queue checked by a monitor.
// ---------------------------------------------------------------------------
module tb_lsu_misalign_unit;
    import lsu_misalign_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (misaligned allowed) ----------------
    logic        flush = 1'b0;
    mem_op_t     req_op = MEM_NOP;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        dmem_wr_en;
    mem_op_t     dmem_ctrl;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic        stall, misalign_exc;
    logic [15:0] split_count;

    lsu_misalign_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_wr_en(dmem_wr_en), .dmem_ctrl(dmem_ctrl), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .load_data(load_data),
        .stall(stall), .misalign_exc(misalign_exc), .split_count(split_count)
    );

    // ---------------- DUT (misaligned suppressed) ----------------
    mem_op_t     nm_op = MEM_NOP;
    logic [31:0] nm_addr = 32'd0;
    logic [31:0] nm_wdata = 32'd0;
    logic        nm_wr_en;
    mem_op_t     nm_ctrl;
    logic [31:0] nm_maddr, nm_mwdata, nm_rdata, nm_load_data;
    logic        nm_stall, nm_exc;
    logic [15:0] nm_split_count;

    lsu_misalign_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_op(nm_op), .req_addr(nm_addr), .req_wdata(nm_wdata),
        .dmem_wr_en(nm_wr_en), .dmem_ctrl(nm_ctrl), .dmem_addr(nm_maddr),
        .dmem_wdata(nm_mwdata), .dmem_rdata(nm_rdata), .load_data(nm_load_data),
        .stall(nm_stall), .misalign_exc(nm_exc), .split_count(nm_split_count)
    );

    // ---------------- data memories ----------------
    logic [7:0] mem  [0:1023] = '{default: 8'h00};
    logic [7:0] mem2 [0:1023] = '{default: 8'h00};
    logic [9:0] a1, a2;

    function automatic logic [31:0] rd_ext(input mem_op_t c, input logic [7:0] b0, b1, b2, b3);
        case (c)
            MEM_LB:  rd_ext = {{24{b0[7]}}, b0};
            MEM_LBU: rd_ext = {24'd0, b0};
            MEM_LH:  rd_ext = {{16{b1[7]}}, b1, b0};
            MEM_LHU: rd_ext = {16'd0, b1, b0};
            MEM_LW:  rd_ext = {b3, b2, b1, b0};
            default: rd_ext = 32'd0;
        endcase
    endfunction

    always_comb begin
        a1 = dmem_addr[9:0];
        a2 = nm_maddr[9:0];
        dmem_rdata = rd_ext(dmem_ctrl, mem[a1], mem[a1 + 10'd1], mem[a1 + 10'd2], mem[a1 + 10'd3]);
        nm_rdata   = rd_ext(nm_ctrl, mem2[a2], mem2[a2 + 10'd1], mem2[a2 + 10'd2], mem2[a2 + 10'd3]);
    end

    always @(posedge clk) begin
        if (dmem_wr_en) begin
            case (dmem_ctrl)
                MEM_SB: mem[a1] <= dmem_wdata[7:0];
                MEM_SH: begin mem[a1] <= dmem_wdata[7:0]; mem[a1 + 10'd1] <= dmem_wdata[15:8]; end
                MEM_SW: begin
                    mem[a1] <= dmem_wdata[7:0];          mem[a1 + 10'd1] <= dmem_wdata[15:8];
                    mem[a1 + 10'd2] <= dmem_wdata[23:16]; mem[a1 + 10'd3] <= dmem_wdata[31:24];
                end
                default: ;
            endcase
        end
        if (nm_wr_en) begin
            case (nm_ctrl)
                MEM_SB: mem2[a2] <= nm_mwdata[7:0];
                MEM_SH: begin mem2[a2] <= nm_mwdata[7:0]; mem2[a2 + 10'd1] <= nm_mwdata[15:8]; end
                MEM_SW: begin
                    mem2[a2] <= nm_mwdata[7:0];          mem2[a2 + 10'd1] <= nm_mwdata[15:8];
                    mem2[a2 + 10'd2] <= nm_mwdata[23:16]; mem2[a2 + 10'd3] <= nm_mwdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a load result is presented when stall is low on a load op.
    always @(negedge clk) begin
        if (rst_n && !flush && !stall && mem_op_is_load(req_op)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_load: got 0x%08h expected no output", load_data);
            end else begin
                chk("load_data", load_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Presents one request and holds it until stall drops; reports stall cycles.
    task automatic do_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         output int stalls);
        bit done;
        req_op = op; req_addr = addr; req_wdata = wdata;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL op_timeout: got stall stuck high expected completion within 8 cycles");
        end
        req_op = MEM_NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int st;

        // Reset with an active request applied: outputs must stay quiet.
        req_op = MEM_SW; req_addr = 32'h100; req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",   {31'd0, dmem_wr_en}, 32'd0);
        chk("rst_ctrl",    32'(dmem_ctrl), 32'(MEM_NOP));
        chk("rst_addr",    dmem_addr, 32'd0);
        chk("rst_wdata",   dmem_wdata, 32'd0);
        chk("rst_stall",   {31'd0, stall}, 32'd0);
        chk("rst_count",   {16'd0, split_count}, 32'd0);
        req_op = MEM_NOP; req_addr = 32'd0; req_wdata = 32'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: aligned word store / load / signed byte load
        do_op(MEM_SW, 32'd100, 32'h89AB_CDEF, st);
        chk("t1_sw_stall", st, 0);
        exp_q.push_back(32'h89AB_CDEF);
        do_op(MEM_LW, 32'd100, 32'd0, st);
        chk("t1_lw_stall", st, 0);
        exp_q.push_back(32'hFFFF_FFEF);
        do_op(MEM_LB, 32'd100, 32'd0, st);

        // 2: misaligned word store / load
        do_op(MEM_SW, 32'd101, 32'h1122_3344, st);
        chk("t2_sw_stall", st, 3);
        chk("t2_mem101", {24'd0, mem[101]}, 32'h44);
        chk("t2_mem102", {24'd0, mem[102]}, 32'h33);
        chk("t2_mem103", {24'd0, mem[103]}, 32'h22);
        chk("t2_mem104", {24'd0, mem[104]}, 32'h11);
        chk("t2_mem100_kept", {24'd0, mem[100]}, 32'hEF);
        exp_q.push_back(32'h1122_3344);
        do_op(MEM_LW, 32'd101, 32'd0, st);
        chk("t2_lw_stall", st, 3);
        exp_q.push_back(32'h0000_0011);
        do_op(MEM_LBU, 32'd104, 32'd0, st);

        // 3: misaligned halfword store, signed and unsigned loads
        do_op(MEM_SH, 32'd103, 32'h0000_80FF, st);
        chk("t3_sh_stall", st, 1);
        exp_q.push_back(32'hFFFF_80FF);
        do_op(MEM_LH, 32'd103, 32'd0, st);
        chk("t3_lh_stall", st, 1);
        exp_q.push_back(32'h0000_80FF);
        do_op(MEM_LHU, 32'd103, 32'd0, st);
        chk("t3_lhu_stall", st, 1);
        chk("t3_split_count", {16'd0, split_count}, 32'd5);

        // 4: flush in the second cycle of a misaligned LW
        req_op = MEM_LW; req_addr = 32'd101;
        @(negedge clk);
        chk("t4_first_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_ctrl",  32'(dmem_ctrl), 32'(MEM_NOP));
        chk("t4_flush_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        chk("t4_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_op = MEM_NOP;
        chk("t4_split_count", {16'd0, split_count}, 32'd6);
        exp_q.push_back(32'hFF33_44EF);
        do_op(MEM_LW, 32'd100, 32'd0, st);
        chk("t4_lw_stall", st, 0);

        // 5: reset during the third cycle of a misaligned SW
        req_op = MEM_SW; req_addr = 32'd201; req_wdata = 32'hA1B2_C3D4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        chk("t5_rst_ctrl",  32'(dmem_ctrl), 32'(MEM_NOP));
        chk("t5_rst_addr",  dmem_addr, 32'd0);
        chk("t5_rst_wdata", dmem_wdata, 32'd0);
        chk("t5_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        req_op = MEM_NOP; req_addr = 32'd0; req_wdata = 32'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_mem201", {24'd0, mem[201]}, 32'hD4);
        chk("t5_mem202", {24'd0, mem[202]}, 32'hC3);
        chk("t5_mem203", {24'd0, mem[203]}, 32'h00);
        chk("t5_mem204", {24'd0, mem[204]}, 32'h00);
        chk("t5_split_count", {16'd0, split_count}, 32'd0);
        exp_q.push_back(32'h0000_00D4);
        do_op(MEM_LBU, 32'd201, 32'd0, st);

        // 6: misaligned ops suppressed when splitting is disabled
        nm_op = MEM_LW; nm_addr = 32'd102;
        @(negedge clk);
        chk("t6_exc",   {31'd0, nm_exc}, 32'd1);
        chk("t6_ctrl",  32'(nm_ctrl), 32'(MEM_NOP));
        chk("t6_wr_en", {31'd0, nm_wr_en}, 32'd0);
        chk("t6_stall", {31'd0, nm_stall}, 32'd0);
        @(posedge clk); #1;
        nm_op = MEM_NOP;
        @(negedge clk);
        chk("t6_exc_pulse", {31'd0, nm_exc}, 32'd0);
        @(posedge clk); #1;
        nm_op = MEM_SW; nm_addr = 32'd102; nm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_sw_wr_en", {31'd0, nm_wr_en}, 32'd0);
        @(posedge clk); #1;
        nm_op = MEM_NOP;
        chk("t6_mem_unchanged", {mem2[105], mem2[104], mem2[103], mem2[102]}, 32'd0);
        chk("t6_split_count", {16'd0, nm_split_count}, 32'd0);
        nm_op = MEM_SW; nm_addr = 32'd100; nm_wdata = 32'h0102_0304;
        @(negedge clk);
        chk("t6_aligned_wr_en", {31'd0, nm_wr_en}, 32'd1);
        @(posedge clk); #1;
        nm_op = MEM_LW; nm_addr = 32'd100;
        @(negedge clk);
        chk("t6_aligned_lw", nm_load_data, 32'h0102_0304);
        @(posedge clk); #1;
        nm_op = MEM_NOP;

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
